// File: rtl/adder_tree_operand_sequencer.sv
// Serial operand collector and result-capture stage for the 8-operand adder tree.
// Optional running-sum self-check enabled by defining ADDER_TREE_SEQ_CHECK_EN.
module adder_tree_operand_sequencer #(
   parameter int WIDTH         = 7,
   parameter int SETTLE_CYCLES = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             abort,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_ci,
   output logic [WIDTH-1:0] op_a,
   output logic [WIDTH-1:0] op_b,
   output logic [WIDTH-1:0] op_c,
   output logic [WIDTH-1:0] op_d,
   output logic [WIDTH-1:0] op_e,
   output logic [WIDTH-1:0] op_f,
   output logic [WIDTH-1:0] op_g,
   output logic [WIDTH-1:0] op_h,
   output logic             op_ci,
   input  logic [WIDTH-1:0] tree_s,
   input  logic             tree_co,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [WIDTH-1:0] res_sum,
   output logic             res_co,
   output logic             chk_err
);

   localparam logic [1:0] ST_FILL   = 2'd0;
   localparam logic [1:0] ST_SETTLE = 2'd1;
   localparam logic [1:0] ST_HOLD   = 2'd2;
   localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES);

   logic [1:0]       r_state;
   logic [2:0]       r_count;
   logic [3:0]       r_settle;
   logic [WIDTH-1:0] r_slot [8];
   logic             r_op_ci;
   logic [WIDTH-1:0] r_res_sum;
   logic             r_res_co;
   logic             r_res_valid;

   logic w_abort_eff;
   logic w_accept;
   logic w_capture;

   // A presented result is never dropped, so abort only acts outside HOLD.
   assign w_abort_eff = abort && (r_state != ST_HOLD);
   assign w_accept    = (r_state == ST_FILL) && in_valid && !abort;
   assign w_capture   = (r_state == ST_SETTLE) && !abort && (r_settle == 4'd1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_FILL;
         r_count     <= 3'd0;
         r_settle    <= 4'd0;
         r_res_valid <= 1'b0;
      end else if (w_abort_eff) begin
         r_state <= ST_FILL;
         r_count <= 3'd0;
      end else begin
         case (r_state)
            ST_FILL: begin
               if (in_valid) begin
                  r_count <= r_count + 3'd1;
                  if (r_count == 3'd7) begin
                     r_state  <= ST_SETTLE;
                     r_settle <= SETTLE_LOAD;
                  end
               end
            end
            ST_SETTLE: begin
               if (r_settle == 4'd1) begin
                  r_state     <= ST_HOLD;
                  r_res_valid <= 1'b1;
               end else begin
                  r_settle <= r_settle - 4'd1;
               end
            end
            ST_HOLD: begin
               if (res_ready) begin
                  r_state     <= ST_FILL;
                  r_res_valid <= 1'b0;
               end
            end
            default: r_state <= ST_FILL;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 8; i++) r_slot[i] <= '0;
         r_op_ci <= 1'b0;
      end else if (w_accept) begin
         r_slot[r_count] <= in_data;
         if (r_count == 3'd0) r_op_ci <= in_ci;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_res_sum <= '0;
         r_res_co  <= 1'b0;
      end else if (w_capture) begin
         r_res_sum <= tree_s;
         r_res_co  <= tree_co;
      end
   end

`ifdef ADDER_TREE_SEQ_CHECK_EN
   localparam int ACC_W = WIDTH + 3;
   logic [ACC_W-1:0] r_acc;
   logic             r_chk_err;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_acc     <= '0;
         r_chk_err <= 1'b0;
      end else begin
         if (w_abort_eff) begin
            r_acc <= '0;
         end else if (w_accept) begin
            if (r_count == 3'd0) r_acc <= ACC_W'(in_data) + ACC_W'(in_ci);
            else                 r_acc <= r_acc + ACC_W'(in_data);
         end
         if (w_capture && (tree_s != r_acc[WIDTH-1:0])) r_chk_err <= 1'b1;
      end
   end

   assign chk_err = r_chk_err;
`else
   assign chk_err = 1'b0;
`endif

   assign in_ready  = (r_state == ST_FILL);
   assign op_a      = r_slot[0];
   assign op_b      = r_slot[1];
   assign op_c      = r_slot[2];
   assign op_d      = r_slot[3];
   assign op_e      = r_slot[4];
   assign op_f      = r_slot[5];
   assign op_g      = r_slot[6];
   assign op_h      = r_slot[7];
   assign op_ci     = r_op_ci;
   assign res_valid = r_res_valid;
   assign res_sum   = r_res_sum;
   assign res_co    = r_res_co;

endmodule

// File: tb/tb_adder_tree_operand_sequencer.sv
// Randomized self-checking bench for adder_tree_operand_sequencer with a behavioural adder-tree model.
module tb_adder_tree_operand_sequencer;

   localparam int WIDTH  = 7;
   localparam int SETTLE = 2;
`ifdef ADDER_TREE_SEQ_CHECK_EN
   localparam bit CHK_EN = 1'b1;
`else
   localparam bit CHK_EN = 1'b0;
`endif

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             abort = 1'b0;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [WIDTH-1:0] in_data = '0;
   logic             in_ci = 1'b0;
   logic [WIDTH-1:0] op_a, op_b, op_c, op_d, op_e, op_f, op_g, op_h;
   logic             op_ci;
   logic [WIDTH-1:0] tree_s;
   logic             tree_co;
   logic             res_valid;
   logic             res_ready = 1'b0;
   logic [WIDTH-1:0] res_sum;
   logic             res_co;
   logic             chk_err;

   logic [WIDTH-1:0] tree_xor = '0;
   logic [9:0]       tree_exact;
   logic [55:0]      all_ops;

   int         n_tests = 0;
   int         n_fail  = 0;
   int         hs_count = 0;
   logic       exp_chk = 1'b0;
   logic [6:0] b_ops [8];
   logic       b_ci;

   adder_tree_operand_sequencer #(.WIDTH(WIDTH), .SETTLE_CYCLES(SETTLE)) dut (
      .clk(clk), .rst_n(rst_n), .abort(abort),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_ci(in_ci),
      .op_a(op_a), .op_b(op_b), .op_c(op_c), .op_d(op_d),
      .op_e(op_e), .op_f(op_f), .op_g(op_g), .op_h(op_h), .op_ci(op_ci),
      .tree_s(tree_s), .tree_co(tree_co),
      .res_valid(res_valid), .res_ready(res_ready),
      .res_sum(res_sum), .res_co(res_co), .chk_err(chk_err)
   );

   always #5 clk = ~clk;

   // Combinational adder tree; tree_xor lets a batch present a wrong sum.
   assign tree_exact = 10'(op_a) + 10'(op_b) + 10'(op_c) + 10'(op_d)
                     + 10'(op_e) + 10'(op_f) + 10'(op_g) + 10'(op_h) + 10'(op_ci);
   assign tree_s  = tree_exact[6:0] ^ tree_xor;
   assign tree_co = |tree_exact[9:7];
   assign all_ops = {op_a, op_b, op_c, op_d, op_e, op_f, op_g, op_h};

   always @(posedge clk) if (in_valid && in_ready) hs_count++;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic int ref_total();
      int s = int'(b_ci);
      foreach (b_ops[i]) s += int'(b_ops[i]);
      return s;
   endfunction

   function automatic logic [6:0] ref_sum();
      return 7'(ref_total()) ^ tree_xor;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic rand_batch();
      foreach (b_ops[i]) b_ops[i] = 7'($urandom_range(0, 127));
      b_ci = 1'($urandom);
   endtask

   task automatic send_op(input logic [6:0] d, input logic c, input int bubble_pct);
      int w = 0;
      while (int'($urandom_range(0, 99)) < bubble_pct) tick();
      in_valid = 1'b1;
      in_data  = d;
      in_ci    = c;
      while (!in_ready && w < 50) begin
         tick();
         w++;
      end
      n_tests++;
      if (!in_ready) begin
         n_fail++;
         $display("FAIL send_op_timeout: in_ready=%0b want 1", in_ready);
      end
      tick();
      in_valid = 1'b0;
      in_data  = 7'($urandom);
      in_ci    = 1'($urandom);
   endtask

   task automatic feed_batch(input int bubble_pct);
      for (int i = 0; i < 8; i++)
         send_op(b_ops[i], (i == 0) ? b_ci : 1'($urandom), bubble_pct);
   endtask

   task automatic await_result(input string name);
      int k = 0;
      int t = ref_total();
      while (!res_valid && k < 40) begin
         tick();
         k++;
      end
      n_tests++;
      if (!res_valid || k != SETTLE) begin
         n_fail++;
         $display("FAIL %s_latency: res_valid=%0b after %0d edges, want 1 after %0d", name, res_valid, k, SETTLE);
      end
      n_tests++;
      if (res_sum !== ref_sum()) begin
         n_fail++;
         $display("FAIL %s_sum: got %0d want %0d", name, res_sum, ref_sum());
      end
      n_tests++;
      if (res_co !== (t >= 128)) begin
         n_fail++;
         $display("FAIL %s_co: got %0b want %0b", name, res_co, (t >= 128));
      end
      n_tests++;
      if (in_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL %s_in_ready_hold: got %0b want 0", name, in_ready);
      end
      n_tests++;
      if (chk_err !== exp_chk) begin
         n_fail++;
         $display("FAIL %s_chk_err: got %0b want %0b", name, chk_err, exp_chk);
      end
      $display("[TB] %s: total=%0d res_sum=%0d res_co=%0b latency=%0d", name, t, res_sum, res_co, k);
   endtask

   task automatic ack_result(input string name);
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;
      n_tests++;
      if (res_valid !== 1'b0 || in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL %s_ack: res_valid=%0b in_ready=%0b want 0/1", name, res_valid, in_ready);
      end
      n_tests++;
      if (res_sum !== ref_sum()) begin
         n_fail++;
         $display("FAIL %s_sum_after_ack: got %0d want %0d", name, res_sum, ref_sum());
      end
   endtask

   task automatic expect_no_result(input string name, input int cycles);
      int seen = 0;
      for (int i = 0; i < cycles; i++) begin
         tick();
         if (res_valid !== 1'b0 || in_ready !== 1'b1) seen++;
      end
      n_tests++;
      if (seen != 0) begin
         n_fail++;
         $display("FAIL %s_no_result: %0d bad cycles, want 0", name, seen);
      end
   endtask

   task automatic check_reset_values(input string name);
      n_tests++;
      if (res_valid !== 1'b0 || res_sum !== '0 || res_co !== 1'b0 || chk_err !== 1'b0) begin
         n_fail++;
         $display("FAIL %s_res: valid=%0b sum=%0d co=%0b chk=%0b want all 0", name, res_valid, res_sum, res_co, chk_err);
      end
      n_tests++;
      if (all_ops !== 56'd0 || op_ci !== 1'b0) begin
         n_fail++;
         $display("FAIL %s_ops: ops=%h ci=%0b want 0", name, all_ops, op_ci);
      end
      n_tests++;
      if (in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL %s_in_ready: got %0b want 1", name, in_ready);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      tick();
      check_reset_values("reset");
      $display("[TB] test_reset done");
   endtask

   task automatic test_basic();
      for (int i = 0; i < 8; i++) b_ops[i] = 7'(i + 1);
      b_ci = 1'b1;
      res_ready = 1'b1;
      feed_batch(0);
      await_result("basic");
      n_tests++;
      if (res_sum !== 7'd37) begin
         n_fail++;
         $display("FAIL basic_37: got %0d want 37", res_sum);
      end
      ack_result("basic");
   endtask

   task automatic test_all_max();
      foreach (b_ops[i]) b_ops[i] = 7'd127;
      b_ci = 1'b1;
      feed_batch(0);
      n_tests++;
      if (all_ops !== {8{7'd127}} || op_ci !== 1'b1) begin
         n_fail++;
         $display("FAIL max_ops_settle: ops=%h ci=%0b want all 7f / 1", all_ops, op_ci);
      end
      await_result("all_max");
      n_tests++;
      if (all_ops !== {8{7'd127}} || res_sum !== 7'd121 || res_co !== 1'b1) begin
         n_fail++;
         $display("FAIL max_hold: ops=%h sum=%0d co=%0b want 7f.. / 121 / 1", all_ops, res_sum, res_co);
      end
      ack_result("all_max");
   endtask

   task automatic test_backpressure();
      int bad = 0;
      rand_batch();
      feed_batch(0);
      await_result("backpressure");
      for (int i = 0; i < 6; i++) begin
         tick();
         if (res_valid !== 1'b1 || res_sum !== ref_sum() || in_ready !== 1'b0) bad++;
      end
      n_tests++;
      if (bad != 0) begin
         n_fail++;
         $display("FAIL backpressure_hold: %0d bad cycles, want 0", bad);
      end
      ack_result("backpressure");
      rand_batch();
      feed_batch(0);
      await_result("after_backpressure");
      ack_result("after_backpressure");
   endtask

   task automatic test_bubbles();
      int h0;
      for (int i = 0; i < 8; i++) b_ops[i] = 7'(10 + i);
      b_ci = 1'b0;
      h0 = hs_count;
      feed_batch(50);
      n_tests++;
      if (hs_count - h0 != 8) begin
         n_fail++;
         $display("FAIL bubbles_handshakes: got %0d want 8", hs_count - h0);
      end
      await_result("bubbles");
      n_tests++;
      if (res_sum !== 7'd108 || hs_count - h0 != 8) begin
         n_fail++;
         $display("FAIL bubbles_108: sum=%0d hs=%0d want 108 / 8", res_sum, hs_count - h0);
      end
      ack_result("bubbles");
   endtask

   task automatic test_abort_fill();
      for (int i = 0; i < 3; i++) send_op(7'(50 + i), 1'b1, 0);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      expect_no_result("abort_fill", SETTLE + 4);
      foreach (b_ops[i]) b_ops[i] = 7'd1;
      b_ci = 1'b0;
      feed_batch(0);
      await_result("after_abort_fill");
      n_tests++;
      if (res_sum !== 7'd8 || op_ci !== 1'b0) begin
         n_fail++;
         $display("FAIL abort_fill_8: sum=%0d op_ci=%0b want 8 / 0", res_sum, op_ci);
      end
      ack_result("after_abort_fill");
   endtask

   task automatic test_abort_settle();
      rand_batch();
      feed_batch(0);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      expect_no_result("abort_settle", SETTLE + 3);
      // abort on the same edge as the 8th handshake discards that operand
      rand_batch();
      for (int i = 0; i < 7; i++) send_op(b_ops[i], (i == 0) ? b_ci : 1'b0, 0);
      in_valid = 1'b1;
      in_data  = b_ops[7];
      abort    = 1'b1;
      tick();
      in_valid = 1'b0;
      abort    = 1'b0;
      expect_no_result("abort_8th", SETTLE + 3);
      rand_batch();
      feed_batch(0);
      await_result("after_abort_8th");
      ack_result("after_abort_8th");
   endtask

   task automatic test_abort_hold();
      int bad = 0;
      rand_batch();
      feed_batch(0);
      await_result("abort_hold");
      abort = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         if (res_valid !== 1'b1 || res_sum !== ref_sum()) bad++;
      end
      abort = 1'b0;
      n_tests++;
      if (bad != 0) begin
         n_fail++;
         $display("FAIL abort_hold_retained: %0d bad cycles, want 0", bad);
      end
      ack_result("abort_hold");
   endtask

   task automatic test_chk_err();
      rand_batch();
      tree_xor = 7'd1;
      exp_chk  = CHK_EN;
      feed_batch(0);
      await_result("chk_bad");
      ack_result("chk_bad");
      tree_xor = 7'd0;
      rand_batch();
      feed_batch(20);
      await_result("chk_sticky");
      ack_result("chk_sticky");
   endtask

   task automatic test_reset_settle();
      rand_batch();
      feed_batch(0);
      tick();
      rst_n = 1'b0;
      #1;
      exp_chk = 1'b0;
      check_reset_values("reset_settle");
      tick();
      rst_n = 1'b1;
      expect_no_result("reset_settle", SETTLE + 3);
      rand_batch();
      feed_batch(0);
      await_result("after_reset");
      ack_result("after_reset");
   endtask

   initial begin
      test_reset();
      test_basic();
      test_all_max();
      test_backpressure();
      test_bubbles();
      test_abort_fill();
      test_abort_settle();
      test_abort_hold();
      test_chk_err();
      test_reset_settle();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/adder_tree_operand_sequencer.md
Name: adder_tree_operand_sequencer

Overview:
- Upstream feeder and result-capture stage for the 8-operand, 7-bit adder tree.
- Collects eight 7-bit operands serially over a valid/ready stream, plus a carry-in taken with the first operand.
- Holds all operands stable on parallel outputs that drive the tree directly.
- Waits a programmable settle time, then registers the tree's sum/carry and offers it downstream over a second valid/ready handshake.

Parameters:
- WIDTH, 7, operand and sum width in bits; must match the tree.
- SETTLE_CYCLES, 2, clock cycles allowed for the combinational tree to settle; legal range 1..15.

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- abort  in  1  synchronous; discards any in-progress batch
- in_valid  in  1  operand present
- in_ready  out  1  sequencer accepts an operand
- in_data  in  WIDTH  operand value
- in_ci  in  1  carry-in; sampled only with operand 0
- op_a, op_b, op_c, op_d, op_e, op_f, op_g, op_h  out  WIDTH each  operand slots 0..7, registered, to tree inputs a..h
- op_ci  out  1  registered carry-in, to tree ci
- tree_s  in  WIDTH  tree sum
- tree_co  in  1  tree carry-out
- res_valid  out  1  result available
- res_ready  in  1  downstream accepts the result
- res_sum  out  WIDTH  captured sum
- res_co  out  1  captured carry-out
- chk_err  out  1  self-check mismatch flag (see Optional Feature)

Behaviour:
- Reset (async assert, sync release):
  - state = FILL, count = 0.
  - All op_* = 0, op_ci = 0.
  - res_sum = 0, res_co = 0, res_valid = 0, chk_err = 0.
  - in_ready = 1 from the first cycle after release.
- States: FILL, SETTLE, HOLD.
- in_ready = (state == FILL), decoded from state; no combinational path from in_valid.
- FILL:
  - Handshake = in_valid && in_ready at a rising edge.
  - On handshake: slot[count] <= in_data; count += 1.
  - If count == 0, also op_ci <= in_ci.
  - Bubbles (in_valid low) are allowed; slots already written keep their values.
  - On the 8th handshake (count == 7): go to SETTLE, load settle counter with SETTLE_CYCLES, wrap count to 0.
- SETTLE:
  - in_ready = 0; op_* are frozen.
  - Settle counter decrements each cycle.
  - On the edge where it reaches 0: res_sum <= tree_s, res_co <= tree_co, res_valid <= 1, go to HOLD.
  - Latency: 8th handshake at edge N, capture at edge N+SETTLE_CYCLES, res_valid visible after that edge.
- HOLD:
  - res_valid = 1; res_sum/res_co stable; op_* still frozen.
  - On res_valid && res_ready: res_valid <= 0, go to FILL.
  - in_ready rises the cycle after the result handshake; no overlap of output accept and input accept in the same cycle.
  - res_sum/res_co keep their last value after the handshake.
- abort:
  - Highest priority among synchronous events.
  - In FILL or SETTLE: count = 0, go to FILL, no result produced. op_* retain their stale values.
  - In HOLD: ignored; a presented result is never dropped.
  - abort coinciding with the 8th handshake: abort wins and the operand is discarded.
- Arithmetic: none in the sequencer; tree_s/tree_co pass through unmodified. The exact sum can reach 10 bits (8*127+1 = 1017); only tree_s equals exact_sum mod 2^WIDTH.
- Reset mid-operation returns to the reset state immediately; a partial batch or pending result is lost.

Optional Feature:
- Macro: ADDER_TREE_SEQ_CHECK_EN.
- Defined:
  - A 10-bit running accumulator clears on handshake of operand 0 and adds each accepted operand; op_ci is added at operand 0.
  - At capture, chk_err <= (tree_s != acc[WIDTH-1:0]).
  - chk_err is sticky until reset. tree_co is not checked.
  - abort clears the accumulator but not chk_err.
- Not defined: no accumulator is built; chk_err is tied to 0.

Test Plan:
- Operands 1,2,3,4,5,6,7,8 with ci=1, res_ready=1, SETTLE_CYCLES=2 -> res_sum=37, res_valid asserted 2 edges after the 8th handshake; chk_err=0.
- All operands 127, ci=1 -> res_sum=121 (1017 mod 128), op_a..op_h all 127 and stable through SETTLE and HOLD.
- Hold res_ready=0 for 6 cycles after res_valid -> res_sum/res_valid unchanged and in_ready=0 throughout; release -> in_ready=1 on the next cycle, next batch accepted.
- Random in_valid bubbles (50%) with operands 10..17, ci=0 -> res_sum=108, and exactly 8 handshakes before SETTLE.
- Cases, one per batch:
  - abort after 3 operands -> count=0, no res_valid; a following batch of eight 1s with ci=0 gives res_sum=8.
  - abort during HOLD -> result retained.
  - rst_n low during SETTLE -> all outputs at reset values.
- With ADDER_TREE_SEQ_CHECK_EN: bench forces tree_s to expected XOR 1 on one batch -> chk_err=1 after capture and stays 1 across later correct batches until reset.
